// File: rtl/hdr_pipe_pkg.sv
// Shared header-pipe types and default sizes for the header buffer / parser path.
// The typedefs describe the default-sized header word and length.
package hdr_pipe_pkg;

  localparam int HDR_BYTES_DEFAULT = 192;
  localparam int HDR_PTR_W_DEFAULT = 8;
  localparam int HDR_DEPTH_DEFAULT = 4;
  localparam int HDR_WORD_W        = 8 * HDR_BYTES_DEFAULT;

  typedef logic [HDR_PTR_W_DEFAULT:0] hdr_len_t;
  typedef logic [HDR_WORD_W-1:0]      hdr_word_t;

  typedef struct packed {
    hdr_len_t  len;
    hdr_word_t flat;
  } hdr_entry_t;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hdr_buf_ram.sv
// DEPTH-entry register file holding header word plus length.
// One synchronous write port, one asynchronous read port; contents are not reset.
module hdr_buf_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read gives first-word-fall-through at the head pointer.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/hdr_parser_elastic_buf.sv
// Elastic buffer between the header buffer and the parser FSM: DEPTH-entry FIFO with
// registered upstream ready, occupancy, synchronous flush and a sticky length-error flag.
module hdr_parser_elastic_buf
  import hdr_pipe_pkg::*;
#(
  parameter int HEADER_BYTES = HDR_BYTES_DEFAULT,
  parameter int PTR_W        = HDR_PTR_W_DEFAULT,
  parameter int DEPTH        = HDR_DEPTH_DEFAULT,
  localparam int AW          = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1),
  localparam int DW          = 8 * HEADER_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             header_valid,
  input  logic [DW-1:0]    header_flat,
  input  logic [PTR_W:0]   header_len,
  output logic             header_ready,
  output logic             hdr_valid,
  output logic [DW-1:0]    hdr_flat,
  output logic [PTR_W:0]   hdr_len,
  input  logic             hdr_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy,
  output logic             len_err
);

  localparam int            EW      = DW + PTR_W + 1;
  localparam logic [PTR_W:0] MAX_LEN = (PTR_W + 1)'(HEADER_BYTES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             len_err_q, len_err_d;

  logic             push;
  logic             pop;
  logic             wr_en;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;

  assign push  = header_valid & ready_q;
  assign pop   = (count_q != '0) & hdr_ready;
  // A push coinciding with flush is dropped, so it must not touch storage either.
  assign wr_en = push & ~flush;

  assign wr_entry = {header_len, header_flat};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    len_err_d = len_err_q;
    ready_d   = 1'b1;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      len_err_d = 1'b0;
      ready_d   = 1'b1;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (header_len > MAX_LEN) begin
          len_err_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // Ready is registered from the post-update count, so the upstream never
      // sees a combinational path from the parser's hdr_ready.
      ready_d = (count_d < FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      len_err_q <= len_err_d;
    end
  end

  hdr_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  assign header_ready = ready_q;
  assign hdr_valid    = (count_q != '0);
  assign hdr_len      = rd_entry[EW-1 -: PTR_W + 1];
  assign hdr_flat     = rd_entry[DW-1:0];
  assign occupancy    = count_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_hdr_parser_elastic_buf.sv
// Self-checking bench for hdr_parser_elastic_buf: directed scenarios plus a random
// run checked against a queue-based model of the buffer.
module tb_hdr_parser_elastic_buf;
  import hdr_pipe_pkg::*;

  localparam int HB    = 192;
  localparam int PW    = 8;
  localparam int DEP   = 4;
  localparam int CW    = 3;
  localparam int W     = 8 * HB;

  logic          clk;
  logic          rst_n;
  logic          header_valid;
  logic [W-1:0]  header_flat;
  logic [PW:0]   header_len;
  logic          header_ready;
  logic          hdr_valid;
  logic [W-1:0]  hdr_flat;
  logic [PW:0]   hdr_len;
  logic          hdr_ready;
  logic          flush;
  logic [CW-1:0] occupancy;
  logic          len_err;

  hdr_parser_elastic_buf #(
    .HEADER_BYTES (HB),
    .PTR_W        (PW),
    .DEPTH        (DEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .header_valid (header_valid),
    .header_flat  (header_flat),
    .header_len   (header_len),
    .header_ready (header_ready),
    .hdr_valid    (hdr_valid),
    .hdr_flat     (hdr_flat),
    .hdr_len      (hdr_len),
    .hdr_ready    (hdr_ready),
    .flush        (flush),
    .occupancy    (occupancy),
    .len_err      (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a plain FIFO of accepted headers plus the predicted ready and error flag.
  hdr_entry_t q[$];
  logic       exp_ready = 1'b0;
  logic       exp_err   = 1'b0;
  int         n_popped  = 0;

  function automatic logic [W-1:0] rand_flat();
    logic [W-1:0] f;
    for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, return at the negedge.
  task automatic tick(input logic hv, input logic [PW:0] len, input logic [W-1:0] flat,
                      input logic rdy, input logic fl);
    logic       do_push;
    logic       do_pop;
    hdr_entry_t e;
    header_valid = hv;
    header_len   = len;
    header_flat  = flat;
    hdr_ready    = rdy;
    flush        = fl;
    do_push = hv && exp_ready;
    do_pop  = rdy && (q.size() != 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
      exp_err   = 1'b0;
      exp_ready = 1'b1;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        n_popped++;
      end
      if (do_push) begin
        e.len  = len;
        e.flat = flat;
        q.push_back(e);
        if (int'(len) > HB) exp_err = 1'b1;
      end
      exp_ready = (q.size() < DEP);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) tick(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    header_valid = 1'b0; header_flat = '0; header_len = '0;
    hdr_ready = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", header_ready); end
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", hdr_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got=%b exp=0", len_err); end
    rst_n = 1'b1;
    #1;
    checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got=%b exp=0", header_ready); end
    @(posedge clk);
    exp_ready = 1'b1;
    @(negedge clk);
    checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", header_ready); end
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got=%b exp=0", hdr_valid); end
  endtask

  task automatic test_single();
    logic [W-1:0] f;
    f = rand_flat();
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%b exp=0", hdr_valid); end
    tick(1'b1, 9'd54, f, 1'b1, 1'b0);
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", hdr_valid); end
    checks++; if (hdr_len !== 9'd54) begin errors++; $display("FAIL single_len got=%0d exp=54", hdr_len); end
    checks++; if (hdr_flat !== f) begin errors++; $display("FAIL single_flat got=%h exp=%h", hdr_flat[63:0], f[63:0]); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ0 got=%0d exp=0", occupancy); end
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL single_post_valid got=%b exp=0", hdr_valid); end
  endtask

  task automatic test_fill_drain();
    logic [PW:0] l;
    for (int i = 1; i <= DEP; i++) begin
      l = 9'(i);
      tick(1'b1, l, rand_flat(), 1'b0, 1'b0);
    end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", header_ready); end
    tick(1'b1, 9'd99, rand_flat(), 1'b0, 1'b0);
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_ignored_occ got=%0d exp=4", occupancy); end
    checks++; if (hdr_len !== 9'd1) begin errors++; $display("FAIL fill_head got=%0d exp=1", hdr_len); end
    for (int i = 1; i <= DEP; i++) begin
      l = 9'(i);
      checks++; if (hdr_valid !== 1'b1 || hdr_len !== l) begin
        errors++; $display("FAIL drain_order got=%b/%0d exp=1/%0d", hdr_valid, hdr_len, i);
      end
      tick(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (hdr_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL drain_empty got=%b/%0d exp=0/0", hdr_valid, occupancy);
    end
    checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got=%b exp=1", header_ready); end
  endtask

  task automatic test_streaming();
    int          start_pops;
    logic [PW:0] l;
    start_pops = n_popped;
    for (int c = 0; c < 100; c++) begin
      l = 9'(c % 180);
      tick(1'b1, l, rand_flat(), 1'b1, 1'b0);
      checks++; if (hdr_valid !== 1'b1 || occupancy !== 3'd1) begin
        errors++; $display("FAIL stream_bubble cyc=%0d valid=%b occ=%0d exp=1/1", c, hdr_valid, occupancy);
      end
      checks++; if (hdr_len !== q[0].len || hdr_flat !== q[0].flat) begin
        errors++; $display("FAIL stream_data cyc=%0d got=%0d exp=%0d", c, hdr_len, q[0].len);
      end
    end
    checks++; if (n_popped - start_pops != 99) begin
      errors++; $display("FAIL stream_rate got=%0d exp=99", n_popped - start_pops);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [W-1:0] f;
    f = rand_flat();
    tick(1'b1, 9'd200, f, 1'b0, 1'b0);
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_set got=%b exp=1", len_err); end
    checks++; if (hdr_len !== 9'd200 || hdr_flat !== f) begin
      errors++; $display("FAIL len_err_stored got=%0d exp=200", hdr_len);
    end
    tick(1'b1, 9'd10, rand_flat(), 1'b0, 1'b0);
    tick(1'b1, 9'd11, rand_flat(), 1'b0, 1'b0);
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
    tick(1'b1, 9'd77, rand_flat(), 1'b0, 1'b1);
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", hdr_valid); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL flush_len_err got=%b exp=0", len_err); end
    checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", header_ready); end
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (occupancy !== 3'd0 || hdr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_push_dropped got=%0d exp=0", occupancy);
    end
  endtask

  task automatic test_random();
    logic         hv, rdy, fl, stalled;
    logic [PW:0]  l;
    logic [W-1:0] held_flat;
    logic [PW:0]  held_len;
    stalled = 1'b0;
    held_flat = '0;
    held_len = '0;
    for (int c = 0; c < 10000; c++) begin
      hv  = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 299) == 0);
      l   = 9'($urandom_range(0, 230));
      if (stalled) begin
        checks++; if (hdr_flat !== held_flat || hdr_len !== held_len) begin
          errors++; $display("FAIL rnd_stable cyc=%0d got=%0d exp=%0d", c, hdr_len, held_len);
        end
      end
      stalled   = hdr_valid && !rdy && !fl;
      held_flat = hdr_flat;
      held_len  = hdr_len;
      tick(hv, l, rand_flat(), rdy, fl);
      checks++; if (header_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, header_ready, exp_ready);
      end
      checks++; if (occupancy !== 3'(q.size())) begin
        errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, q.size());
      end
      checks++; if (hdr_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, hdr_valid, q.size() != 0);
      end
      checks++; if (len_err !== exp_err) begin
        errors++; $display("FAIL rnd_len_err cyc=%0d got=%b exp=%b", c, len_err, exp_err);
      end
      if (q.size() != 0) begin
        checks++; if (hdr_len !== q[0].len || hdr_flat !== q[0].flat) begin
          errors++; $display("FAIL rnd_head cyc=%0d got=%0d/%h exp=%0d/%h", c, hdr_len,
                             hdr_flat[63:0], q[0].len, q[0].flat[63:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
